// File: rtl/perceptron_pkg.sv
// Shared types and sizing helpers for the perceptron training sequencer.
package perceptron_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_RECORD    = 3'd2,
        S_EVAL_REQ  = 3'd3,
        S_EVAL_WAIT = 3'd4,
        S_UPDATE    = 3'd5,
        S_FINISH    = 3'd6
    } train_state_t;

    localparam int N_FEAT_DEF = 8000;

    function automatic int addr_w_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/perceptron_train_ctrl_phase_counter.sv
// Feature index counter shared by the record and update phases; holds at the
// last index instead of wrapping so the terminal flag alone ends a phase.
module phase_counter #(
    parameter int N_FEAT = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk,
    input  logic              RST_n,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_FEAT - 1);

    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_last)
            r_cnt <= r_cnt + ADDR_W'(1);
    end

    assign o_last = (r_cnt == LAST);
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Per-sample sequencer: clear datapath, stream features, request hypothesis,
// and on a misclassification walk the weight RAM through one update pass.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int ADDR_W = addr_w_for(N_FEAT_DEF),
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              RST_n,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Bit_Valid,
    input  logic              Label,
    input  logic              Hw_Valid,
    input  logic              Hw,
    output logic              DW_Clr,
    output logic              Record_X,
    output logic              Get,
    output logic              Up_W,
    output logic              Hw_Req,
    output logic              W_We,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  Sample_Cnt,
    output logic [CNT_W-1:0]  Mistake_Cnt
);

    train_state_t      r_state, w_nxt;
    logic              r_abort;
    logic              w_abort_take;
    logic              w_mistake;
    logic              w_cnt_clr, w_cnt_en;
    logic [ADDR_W-1:0] w_cnt;
    logic              w_last;

    assign w_abort_take = Abort && (r_state != S_IDLE);
    assign w_mistake    = (r_state == S_EVAL_WAIT) && Hw_Valid && (Label != Hw) && !Abort;

    // Abort suppresses the bit handshake so the source never loses a bit to a dead sample.
    assign Get      = (r_state == S_RECORD) && Bit_Valid && !Abort;
    assign DW_Clr   = (r_state == S_CLEAR);
    assign Record_X = (r_state == S_RECORD);
    assign Up_W     = (r_state == S_UPDATE);
    assign W_We     = (r_state == S_UPDATE);
    assign Hw_Req   = (r_state == S_EVAL_REQ);
    assign W_Addr   = (r_state == S_UPDATE) ? w_cnt : '0;
    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_FINISH) && !Abort;

    // Holding the counter clear through EVAL_WAIT leaves it at 0 for the first update cycle.
    assign w_cnt_clr = (r_state == S_CLEAR) || (r_state == S_EVAL_WAIT);
    assign w_cnt_en  = Get || (r_state == S_UPDATE);

    phase_counter #(
        .N_FEAT (N_FEAT),
        .ADDR_W (ADDR_W)
    ) u_phase_cnt (
        .Clk    (Clk),
        .RST_n  (RST_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    always_comb begin
        w_nxt = r_state;
        if (w_abort_take) begin
            w_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE:      if (Start) w_nxt = S_CLEAR;
                S_CLEAR:     w_nxt = r_abort ? S_IDLE : S_RECORD;
                S_RECORD:    if (Get && w_last) w_nxt = S_EVAL_REQ;
                S_EVAL_REQ:  w_nxt = S_EVAL_WAIT;
                S_EVAL_WAIT: if (Hw_Valid) w_nxt = (Label != Hw) ? S_UPDATE : S_FINISH;
                S_UPDATE:    if (w_last) w_nxt = S_FINISH;
                S_FINISH:    w_nxt = S_IDLE;
                default:     w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= S_IDLE;
            r_abort     <= 1'b0;
            Sample_Cnt  <= '0;
            Mistake_Cnt <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_abort_take)
                r_abort <= 1'b1;
            else if (r_state == S_IDLE)
                r_abort <= 1'b0;
            if (w_mistake)
                Mistake_Cnt <= Mistake_Cnt + CNT_W'(1);
            if (Done)
                Sample_Cnt <= Sample_Cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl with a 4-feature configuration.
module tb_perceptron_train_ctrl;

    localparam int N_FEAT = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;

    logic              Clk, RST_n;
    logic              Start, Abort, Bit_Valid, Label, Hw_Valid, Hw;
    logic              DW_Clr, Record_X, Get, Up_W, Hw_Req, W_We, Busy, Done;
    logic [ADDR_W-1:0] W_Addr;
    logic [CNT_W-1:0]  Sample_Cnt, Mistake_Cnt;

    perceptron_train_ctrl #(.N_FEAT(N_FEAT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .RST_n(RST_n), .Start(Start), .Abort(Abort), .Bit_Valid(Bit_Valid),
        .Label(Label), .Hw_Valid(Hw_Valid), .Hw(Hw), .DW_Clr(DW_Clr), .Record_X(Record_X),
        .Get(Get), .Up_W(Up_W), .Hw_Req(Hw_Req), .W_We(W_We), .W_Addr(W_Addr), .Busy(Busy),
        .Done(Done), .Sample_Cnt(Sample_Cnt), .Mistake_Cnt(Mistake_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int c_clr, c_get, c_req, c_we, c_upw, c_done, c_both, c_recx;
    logic [ADDR_W-1:0] addrs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        c_clr = 0; c_get = 0; c_req = 0; c_we = 0; c_upw = 0; c_done = 0; c_both = 0; c_recx = 0;
        addrs.delete();
    endtask

    // Observe the current cycle's outputs, then advance to the next falling edge.
    task automatic tick();
        #2;
        if (DW_Clr)        c_clr++;
        if (Get)           c_get++;
        if (Hw_Req)        c_req++;
        if (W_We)          begin c_we++; addrs.push_back(W_Addr); end
        if (Up_W)          c_upw++;
        if (Done)          c_done++;
        if (Record_X)      c_recx++;
        if (Get && Up_W)   c_both++;
        @(negedge Clk);
    endtask

    task automatic start_and_record(input int nbits);
        Start = 1'b1; tick();
        Start = 1'b0; tick();
        Bit_Valid = 1'b1;
        repeat (nbits) tick();
        Bit_Valid = 1'b0;
    endtask

    task automatic finish_eval(input logic hw, input logic lbl);
        tick();
        Hw_Valid = 1'b1; Hw = hw; Label = lbl;
        tick();
        Hw_Valid = 1'b0;
    endtask

    initial begin
        int bv[7] = '{1, 0, 0, 1, 1, 0, 1};
        RST_n = 1'b0; Start = 0; Abort = 0; Bit_Valid = 0; Label = 0; Hw_Valid = 0; Hw = 0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_dwclr", DW_Clr, 0);
        chk("rst_done", Done, 0);
        chk("rst_we", W_We, 0);
        chk("rst_sample", Sample_Cnt, 0);
        chk("rst_mistake", Mistake_Cnt, 0);
        @(negedge Clk); @(negedge Clk);
        RST_n = 1'b1;
        tick();

        // Correct classification
        clr_counts();
        start_and_record(4);
        finish_eval(1'b1, 1'b1);
        #1 chk("t1_done_lat", Done, 1);
        tick(); tick();
        chk("t1_clr_cnt", c_clr, 1);
        chk("t1_get_cnt", c_get, 4);
        chk("t1_rec_cnt", c_recx, 4);
        chk("t1_req_cnt", c_req, 1);
        chk("t1_we_cnt", c_we, 0);
        chk("t1_done_cnt", c_done, 1);
        chk("t1_sample", Sample_Cnt, 1);
        chk("t1_mistake", Mistake_Cnt, 0);
        chk("t1_busy", Busy, 0);

        // Misclassification: full update pass
        clr_counts();
        start_and_record(4);
        finish_eval(1'b1, 1'b0);
        #1 chk("t2_upw_first", Up_W, 1);
        repeat (4) tick();
        #1 chk("t2_done_lat", Done, 1);
        tick(); tick();
        chk("t2_we_cnt", c_we, 4);
        chk("t2_upw_cnt", c_upw, 4);
        chk("t2_addr_n", addrs.size(), 4);
        for (int i = 0; i < 4 && i < addrs.size(); i++)
            chk("t2_addr", addrs[i], i);
        chk("t2_get_upw", c_both, 0);
        chk("t2_done_cnt", c_done, 1);
        chk("t2_sample", Sample_Cnt, 2);
        chk("t2_mistake", Mistake_Cnt, 1);

        // Source stall
        clr_counts();
        Start = 1'b1; tick();
        Start = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin
            Bit_Valid = bv[i][0];
            #1 chk("t3_get_track", Get, bv[i]);
            tick();
        end
        Bit_Valid = 1'b0;
        #1 chk("t3_evalreq", Hw_Req, 1);
        finish_eval(1'b0, 1'b0);
        #1 chk("t3_done", Done, 1);
        tick(); tick();
        chk("t3_get_cnt", c_get, 4);
        chk("t3_sample", Sample_Cnt, 3);
        chk("t3_mistake", Mistake_Cnt, 1);

        // Abort in RECORD after two bits
        clr_counts();
        start_and_record(2);
        Abort = 1'b1; Bit_Valid = 1'b1;
        #1 chk("t4_abort_get", Get, 0);
        tick();
        Abort = 1'b0; Bit_Valid = 1'b0;
        #1 chk("t4_abort_clr", DW_Clr, 1);
        tick();
        #1 chk("t4_abort_idle", Busy, 0);
        tick(); tick();
        chk("t4_done_cnt", c_done, 0);
        chk("t4_get_cnt", c_get, 2);
        chk("t4_sample", Sample_Cnt, 3);
        chk("t4_mistake", Mistake_Cnt, 1);
        clr_counts();
        start_and_record(4);
        finish_eval(1'b0, 1'b1);
        repeat (4) tick();
        #1 chk("t4_post_done", Done, 1);
        tick(); tick();
        chk("t4_post_we", c_we, 4);
        chk("t4_post_sample", Sample_Cnt, 4);
        chk("t4_post_mistake", Mistake_Cnt, 2);

        // Start held while busy, Hw_Valid pulsed during RECORD
        clr_counts();
        Start = 1'b1; tick();
        tick();
        Bit_Valid = 1'b1; Hw_Valid = 1'b1; Hw = 1'b1; Label = 1'b0;
        repeat (4) tick();
        Bit_Valid = 1'b0; Hw_Valid = 1'b0;
        tick();
        Hw_Valid = 1'b1; Hw = 1'b1; Label = 1'b1;
        tick();
        Hw_Valid = 1'b0;
        #1 chk("t5_done", Done, 1);
        Start = 1'b0;
        tick(); tick();
        chk("t5_done_cnt", c_done, 1);
        chk("t5_clr_cnt", c_clr, 1);
        chk("t5_we_cnt", c_we, 0);
        chk("t5_sample", Sample_Cnt, 5);
        chk("t5_mistake", Mistake_Cnt, 2);
        chk("t5_busy", Busy, 0);

        // Async reset in the middle of UPDATE
        clr_counts();
        start_and_record(4);
        finish_eval(1'b1, 1'b0);
        tick(); tick();
        #1 chk("t6_pre_we", W_We, 1);
        RST_n = 1'b0;
        #1;
        chk("t6_we", W_We, 0);
        chk("t6_upw", Up_W, 0);
        chk("t6_addr", W_Addr, 0);
        chk("t6_busy", Busy, 0);
        chk("t6_sample", Sample_Cnt, 0);
        chk("t6_mistake", Mistake_Cnt, 0);
        @(negedge Clk);
        RST_n = 1'b1;
        tick();
        #1 chk("t6_post_busy", Busy, 0);
        chk("t6_post_done", Done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_train_ctrl.md
Name: perceptron_train_ctrl

Overview:
Sequencer for the perceptron weight-update datapath (serial feature shift register plus error × feature multiplier). For each training sample it clears the datapath, streams N_FEAT feature bits in, requests a hypothesis, and on a misclassification steps the datapath through N_FEAT update cycles. Each update cycle drives weight-memory write strobes and addresses. Sits between the serial sample source, the hypothesis unit and the weight RAM.

Parameters:
N_FEAT, 8000, feature bits per sample; equals datapath shift depth
ADDR_W, 13, weight address width; must satisfy 2^ADDR_W >= N_FEAT
CNT_W, 16, width of sample/mistake counters

Ports:
Clk  in  1  system clock
RST_n  in  1  asynchronous active-low reset
Start  in  1  begin one training sample (sampled in IDLE only)
Abort  in  1  cancel current sample
Bit_Valid  in  1  source presents a feature bit
Label  in  1  sample label, sampled on Hw_Valid
Hw_Valid  in  1  hypothesis result valid
Hw  in  1  hypothesis result
DW_Clr  out  1  synchronous clear to datapath (active-high)
Record_X  out  1  datapath record enable
Get  out  1  bit-accept strobe to source and datapath
Up_W  out  1  datapath update shift
Hw_Req  out  1  one-cycle hypothesis request pulse
W_We  out  1  weight RAM write enable
W_Addr  out  ADDR_W  weight RAM address
Busy  out  1  high outside IDLE
Done  out  1  one-cycle pulse at sample completion
Sample_Cnt  out  CNT_W  samples completed
Mistake_Cnt  out  CNT_W  samples that triggered an update

Behaviour:
- Reset: state IDLE; every output 0; all counters 0.
- States: IDLE, CLEAR, RECORD, EVAL_REQ, EVAL_WAIT, UPDATE, FINISH.
- IDLE: on Start=1 -> CLEAR.
- CLEAR (1 cycle): DW_Clr=1; -> RECORD; bit counter = 0.
- RECORD: Record_X=1; Get = Bit_Valid, combinational, same cycle. Each Get increments the bit counter. Get on count N_FEAT-1 -> EVAL_REQ. Bit_Valid=0 stalls with no timeout.
- EVAL_REQ (1 cycle): Hw_Req=1; -> EVAL_WAIT.
- EVAL_WAIT: on Hw_Valid, latch Hw and Label.
  - Label==Hw -> FINISH (no update, no RAM writes).
  - Label!=Hw -> UPDATE; W_Addr=0; Mistake_Cnt+1 (wraps).
- UPDATE: Up_W=1 and W_We=1 every cycle for exactly N_FEAT cycles. W_Addr = k on the cycle the datapath presents the delta for feature k (k = 0..N_FEAT-1, first-recorded bit first). W_Addr increments each cycle. After cycle with W_Addr=N_FEAT-1 -> FINISH.
- FINISH (1 cycle): Done=1; Sample_Cnt+1 (wraps); -> IDLE.
- Latency: Start to first Get >= 2 cycles. Hw_Valid to Done:
  - Label==Hw: 1 cycle.
  - Label!=Hw: N_FEAT+1 cycles.
- Get and Up_W are never high in the same cycle. Record_X is high only in RECORD.
- Abort: in any non-IDLE state, takes priority over all other inputs. Next cycle -> CLEAR, pulsing DW_Clr, then -> IDLE, not RECORD (abort flag). No Done, counters unchanged; writes already issued are not undone.
- Start while Busy: ignored. Hw_Valid outside EVAL_WAIT: ignored.
- Async reset mid-UPDATE: outputs drop to 0 immediately. Datapath content is then undefined until the next CLEAR.
- Bit and address counters saturate-check: a terminal compare of N_FEAT-1 alone ends each phase; no wrap.

Decomposition:
- Package perceptron_pkg holds:
  - state enum train_state_t
  - constant N_FEAT_DEF = 8000
  - function clog2-based ADDR_W helper
- One natural sub-module: phase_counter (load-zero, enable, terminal-count flag at N_FEAT-1). Instantiated once and shared by RECORD and UPDATE, since the phases are mutually exclusive.

Test Plan (N_FEAT=4):
- Reset: RST_n low mid-UPDATE -> all outputs 0 same cycle; after release Busy=0, counters 0.
- Correct classification: Start, bits 1,0,1,1 with Bit_Valid continuous, Hw_Valid with Hw=1, Label=1.
  - DW_Clr 1 cycle, Get exactly 4 cycles, Hw_Req 1 pulse.
  - No W_We; Done 1 cycle after Hw_Valid.
  - Sample_Cnt=1, Mistake_Cnt=0.
- Mistake: same stimulus with Label=0, Hw=1.
  - Up_W/W_We high exactly 4 cycles with W_Addr 0,1,2,3, then Done.
  - Sample_Cnt=1, Mistake_Cnt=1.
- Source stall: Bit_Valid toggles 1,0,0,1,1,0,1 -> Get tracks Bit_Valid; EVAL_REQ entered the cycle after the 4th Get.
- Abort in RECORD after 2 bits -> next cycle DW_Clr=1, then IDLE, no Done, counters unchanged. A following Start runs a normal sample.
- Start held high while Busy and Hw_Valid pulsed during RECORD -> both ignored; exactly one sample completes.
